// File: rtl/gate_bist_sequencer.sv
// gate_bist_sequencer
// BIST sequencer for a 2-input AND gate. It sweeps every {a,b} vector and
// waits a programmable settle time. It then samples y against a & b and
// records the error count and the first failing vector.
module gate_bist_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [1:0]       fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // Terminal counts for the settle and pass counters (8 bits covers 0..255).
    localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [7:0]       pass_q, pass_d;
    logic [7:0]       settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [1:0]       fvec_q, fvec_d;
    logic [1:0]       ab_q, ab_d;
    logic             mismatch;

    // Saturating increment: the error counter sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // Next-state logic: vector sequencing, settle timing, result capture.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        pass_d   = pass_q;
        settle_d = settle_q;
        err_d    = err_q;
        fv_d     = fv_q;
        fvec_d   = fvec_q;
        mismatch = (y != (vec_q[1] & vec_q[0]));
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = 2'd0;
                    pass_d  = 8'd0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = 2'b00;
                end
            end
            S_DRIVE: begin
                settle_d = 8'd0;
                state_d  = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = sat_inc(err_q);
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = S_DRIVE;
                end else if (pass_q != PASS_LAST) begin
                    vec_d   = 2'd0;
                    pass_d  = pass_q + 8'd1;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The gate inputs show the vector only while the sequencer is active.
        ab_d = (state_d == S_DRIVE || state_d == S_SETTLE || state_d == S_CHECK) ? vec_d : 2'b00;
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= 2'd0;
            pass_q   <= 8'd0;
            settle_q <= 8'd0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            fvec_q   <= 2'b00;
            ab_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            pass_q   <= pass_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            fvec_q   <= fvec_d;
            ab_q     <= ab_d;
        end
    end

    assign a          = ab_q[1];
    assign b          = ab_q[0];
    assign busy       = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Bench for gate_bist_sequencer.
// Three instances cover the default configuration, a two-pass run with a
// 2-bit counter, and a zero-settle configuration. A small gate model drives
// y for each instance. Expected vectors and results are queued when a run
// starts and are compared as the DUT produces them.
module tb_gate_bist_sequencer;

    typedef struct packed {
        logic [7:0] err;
        logic       fv;
        logic [1:0] fvec;
        logic       pass;
    } res_t;

    logic       clk;
    logic       rst;
    logic       start_w [3];
    logic       a_w     [3];
    logic       b_w     [3];
    logic       y_w     [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       pass_w  [3];
    logic       fv_w    [3];
    logic [1:0] fvec_w  [3];
    logic [7:0] errc    [3];
    logic [1:0] mode    [3];   // 0 good gate, 1 y stuck at 0, 2 y stuck at 1
    logic [7:0] err0, err2;
    logic [1:0] err1;

    logic [1:0] exp_ab [$];
    res_t       exp_res [$];

    int n_checks = 0;
    int n_errors = 0;

    gate_bist_sequencer u_dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .a(a_w[0]), .b(b_w[0]), .y(y_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err0),
        .fail_valid(fv_w[0]), .fail_vec(fvec_w[0])
    );

    gate_bist_sequencer #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .a(a_w[1]), .b(b_w[1]), .y(y_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err1),
        .fail_valid(fv_w[1]), .fail_vec(fvec_w[1])
    );

    gate_bist_sequencer #(.SETTLE_CYCLES(0), .PASSES(1), .ERR_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .a(a_w[2]), .b(b_w[2]), .y(y_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err2),
        .fail_valid(fv_w[2]), .fail_vec(fvec_w[2])
    );

    assign errc[0] = err0;
    assign errc[1] = {6'b0, err1};
    assign errc[2] = err2;

    // Gate under test: a good AND gate or a stuck-at output.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            case (mode[i])
                2'd0:    y_w[i] = a_w[i] & b_w[i];
                2'd1:    y_w[i] = 1'b0;
                default: y_w[i] = 1'b1;
            endcase
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: expected {a,b} per busy cycle and the final result.
    task automatic push_expect(input int s, input int p, input int w, input logic [1:0] m);
        logic [1:0] vv;
        logic       ym;
        int         errs;
        int         sat;
        res_t       r;
        errs = 0;
        sat  = (1 << w) - 1;
        r    = '0;
        for (int pi = 0; pi < p; pi++) begin
            for (int v = 0; v < 4; v++) begin
                vv = 2'(v);
                for (int c = 0; c < s + 2; c++) exp_ab.push_back(vv);
                ym = (m == 2'd0) ? (vv[1] & vv[0]) : (m == 2'd2);
                if (ym != (vv[1] & vv[0])) begin
                    if (errs < sat) errs++;
                    if (!r.fv) begin
                        r.fv   = 1'b1;
                        r.fvec = vv;
                    end
                end
            end
        end
        r.err  = 8'(errs);
        r.pass = (errs == 0);
        exp_res.push_back(r);
    endtask

    // One complete run. The caller is positioned at a falling edge.
    task automatic run_test(input int idx, input int s, input int p, input int w,
                            input bit inject, input string tag);
        int         cyc;
        int         busy_cnt;
        bit         got_done;
        bit         abort;
        logic [1:0] e;
        res_t       r;
        exp_ab.delete();
        exp_res.delete();
        push_expect(s, p, w, mode[idx]);
        start_w[idx] = 1'b1;
        cyc      = 0;
        busy_cnt = 0;
        got_done = 0;
        abort    = 0;
        while (!got_done && !abort && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start_w[idx] = (inject && cyc == 5);
            if (busy_w[idx]) begin
                busy_cnt++;
                if (cyc == 1) begin
                    check_eq({tag, "_clr_err"}, int'(errc[idx]), 0);
                    check_eq({tag, "_clr_fv"}, int'(fv_w[idx]), 0);
                    check_eq({tag, "_done_low"}, int'(done_w[idx]), 0);
                end
                if (exp_ab.size() > 0) begin
                    e = exp_ab.pop_front();
                    check_eq({tag, "_ab"}, int'({a_w[idx], b_w[idx]}), int'(e));
                end else begin
                    check_eq({tag, "_busy_overrun"}, busy_cnt, p * 4 * (s + 2));
                    abort = 1;
                end
            end else if (done_w[idx]) begin
                got_done = 1;
            end else begin
                check_eq({tag, "_busy"}, int'(busy_w[idx]), 1);
                abort = 1;
            end
        end
        start_w[idx] = 1'b0;
        check_eq({tag, "_done_seen"}, int'(got_done), 1);
        check_eq({tag, "_busy_len"}, busy_cnt, p * 4 * (s + 2));
        r = exp_res.pop_front();
        check_eq({tag, "_err"}, int'(errc[idx]), int'(r.err));
        check_eq({tag, "_fv"}, int'(fv_w[idx]), int'(r.fv));
        check_eq({tag, "_fvec"}, int'(fvec_w[idx]), int'(r.fvec));
        check_eq({tag, "_pass"}, int'(pass_w[idx]), int'(r.pass));
        check_eq({tag, "_ab_done"}, int'({a_w[idx], b_w[idx]}), 0);
        @(negedge clk);
        check_eq({tag, "_done_hold"}, int'(done_w[idx]), 1);
        check_eq({tag, "_err_hold"}, int'(errc[idx]), int'(r.err));
    endtask

    task automatic check_idle(input int idx, input string tag);
        check_eq({tag, "_a"}, int'(a_w[idx]), 0);
        check_eq({tag, "_b"}, int'(b_w[idx]), 0);
        check_eq({tag, "_busy"}, int'(busy_w[idx]), 0);
        check_eq({tag, "_done"}, int'(done_w[idx]), 0);
        check_eq({tag, "_pass"}, int'(pass_w[idx]), 0);
        check_eq({tag, "_err"}, int'(errc[idx]), 0);
        check_eq({tag, "_fv"}, int'(fv_w[idx]), 0);
        check_eq({tag, "_fvec"}, int'(fvec_w[idx]), 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_w[i] = 1'b0;
            mode[i]    = 2'd0;
        end
        repeat (3) @(negedge clk);
        check_idle(0, "reset");
        rst = 1'b0;

        // Good gate with defaults; a start pulse during the run is ignored.
        mode[0] = 2'd0;
        run_test(0, 2, 1, 8, 1'b1, "good");

        // y stuck at 0.
        mode[0] = 2'd1;
        run_test(0, 2, 1, 8, 1'b0, "sa0");

        // Restart from DONE after the failing run, gate now good.
        mode[0] = 2'd0;
        run_test(0, 2, 1, 8, 1'b0, "restart");

        // y stuck at 1, two passes, 2-bit counter saturates.
        mode[1] = 2'd2;
        run_test(1, 2, 2, 2, 1'b0, "sa1sat");

        // Zero settle cycles, good gate.
        mode[2] = 2'd0;
        run_test(2, 0, 1, 8, 1'b0, "nosettle");

        // Reset during vector 2 SETTLE of a failing run.
        mode[0]    = 2'd2;
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("midrun_busy", int'(busy_w[0]), 1);
        check_eq("midrun_ab", int'({a_w[0], b_w[0]}), 2);
        check_eq("midrun_err", int'(errc[0]), 2);
        rst = 1'b1;
        @(negedge clk);
        check_idle(0, "abort");
        rst = 1'b0;
        mode[0] = 2'd0;
        run_test(0, 2, 1, 8, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_bist_sequencer.md
# gate_bist_sequencer

Built-in self-test sequencer for a 2-input AND gate. On a start pulse it drives every `{a,b}` combination into the gate under test, waits a programmable settle time, samples `y`, and checks it against `a & b`. It reports an error count and the first failing vector. The block is the stimulus-and-check stage wrapped around the gate: it feeds the gate's inputs and consumes its output.

## Interface
- `SETTLE_CYCLES`, default 2: wait cycles between driving a vector and sampling `y`; legal range 0..255.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..255.
- `ERR_W`, default 8: width of the error counter.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a run; sampled only in IDLE or DONE.
- `a`  out  1  gate input A, registered.
- `b`  out  1  gate input B, registered.
- `y`  in  1  gate output under test.
- `busy`  out  1  high from the first DRIVE cycle through the last CHECK cycle.
- `done`  out  1  high in DONE; held until the next accepted start or reset.
- `pass`  out  1  high in DONE when `err_count == 0`; low otherwise.
- `err_count`  out  ERR_W  mismatches in the current run; saturates at all-ones.
- `fail_valid`  out  1  set at the first mismatch of a run.
- `fail_vec`  out  2  `{a,b}` of the first mismatch; valid when `fail_valid` is high.

## Operation
- States:
  - IDLE, DRIVE, SETTLE, CHECK, DONE.
  - Registered vector index `vec[1:0]`, with `{a,b} = vec`.
  - Registered pass counter and settle counter.
- IDLE: all outputs 0. If `start` is high, go to DRIVE with `vec=0` and pass counter 0. This also clears `err_count`, `fail_valid` and `fail_vec`.
- DRIVE: one cycle; `{a,b}` is presented. Go to SETTLE if `SETTLE_CYCLES>0`, otherwise to CHECK.
- SETTLE: counts exactly `SETTLE_CYCLES` cycles, then goes to CHECK.
- CHECK: one cycle; at its closing edge, compare `y` against `a & b`.
  - On a mismatch, increment `err_count`; it saturates and never wraps.
  - If `fail_valid` was 0, set it and load `fail_vec={a,b}`.
  - Then:
    - if `vec<3`: increment `vec` and go to DRIVE;
    - else if more passes remain: set `vec=0`, increment the pass counter, go to DRIVE;
    - else go to DONE.
- `a`/`b` hold their value through DRIVE, SETTLE and CHECK. They return to 0 in IDLE and DONE.
- DONE: `done=1` and `pass = (err_count==0)`. Results are held stable. `start` in DONE restarts exactly as from IDLE, clearing all results.
- `start` while `busy` is ignored and has no effect on sequencing or results.
- `y` is assumed combinationally settled within `SETTLE_CYCLES+1` cycles of `a`/`b` changing. No synchronizer is applied.

## Timing
- Reset: state IDLE. `a`, `b`, `busy`, `done`, `pass`, `fail_valid` = 0; `err_count` = 0; `fail_vec` = 2'b00.
- `rst` has priority over `start` in the same cycle.
- `rst` mid-run aborts immediately to the reset values. No partial result survives.
- Start accepted at edge E0: DRIVE of vector 0 is the cycle after E0. `busy` and `a`/`b` update in that same cycle.
- Per vector: `SETTLE_CYCLES+2` cycles.
- Total `busy` duration: `PASSES*4*(SETTLE_CYCLES+2)` cycles.
- `done` rises in the cycle immediately after the final CHECK. `busy` falls in that same cycle; no gap and no overlap.
- `err_count` and `fail_*` update on the edge that closes CHECK. They are visible in the following cycle.
- Simultaneous `start` and entry to DONE: `start` is ignored, because CHECK is a busy state.

## Test plan
- Good gate, defaults: 1-cycle `start` pulse at edge E0.
  - Required: `busy` high for exactly 16 cycles; `{a,b}` steps 00, 01, 10, 11, each held 4 cycles.
  - Then `done=1`, `pass=1`, `err_count=0`, `fail_valid=0`.
- `y` stuck at 0, defaults:
  - Required: `err_count=1`, `fail_valid=1`, `fail_vec=2'b11`, `pass=0`.
- `y` stuck at 1, `PASSES=2`, `ERR_W=2`:
  - Required: 6 mismatches saturate `err_count` at 3; `fail_vec=2'b00`; busy duration 32 cycles.
- `SETTLE_CYCLES=0`, good gate:
  - Required: each vector lasts 2 cycles; busy duration 8 cycles; `pass=1`.
- Reset and start handling:
  - `rst` asserted during vector 2 SETTLE: all outputs 0 on the next cycle, state IDLE.
  - A new `start` then gives a full clean run with `pass=1`.
  - `start` pulsed while `busy`: no effect on timing or results.
- Restart from DONE after a failing run (stuck-at-0), with the gate then made good:
  - Required: results are cleared at restart; the final `err_count=0`, `pass=1`.
